// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: producer/consumer controls, read data and
// status flags. The FIFO side uses the slave modport; the user side uses master.
interface sync_fifo_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);

   logic                flush;
   logic                wr_en;
   logic [DATASIZE-1:0] wdata;
   logic                rd_en;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;
   logic                full;
   logic                empty;
   logic                almost_full;
   logic                almost_empty;
   logic [ADDRSIZE:0]   count;
   logic                overflow;
   logic                underflow;

   modport master (
      output flush,
      output wr_en,
      output wdata,
      output rd_en,
      input  rdata,
      input  rvalid,
      input  full,
      input  empty,
      input  almost_full,
      input  almost_empty,
      input  count,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  flush,
      input  wr_en,
      input  wdata,
      input  rd_en,
      output rdata,
      output rvalid,
      output full,
      output empty,
      output almost_full,
      output almost_empty,
      output count,
      output overflow,
      output underflow
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, registered status flags, threshold
// flags and overflow/underflow fault pulses. Storage style and read-port style
// (first-word-fall-through or registered) are chosen by parameter.
module sync_fifo #(
   parameter int    DATASIZE     = 8,
   parameter int    ADDRSIZE     = 4,
   parameter string FALLTHROUGH  = "TRUE",
   parameter string TYPE         = "distributed",
   parameter int    AFULL_LEVEL  = 14,
   parameter int    AEMPTY_LEVEL = 2
) (
   input logic        clk,
   input logic        rst_n,
   sync_fifo_if.slave fifo
);

   localparam int                DEPTH      = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] CNT_DEPTH  = (ADDRSIZE + 1)'(DEPTH);
   localparam logic [ADDRSIZE:0] CNT_AFULL  = (ADDRSIZE + 1)'(AFULL_LEVEL);
   localparam logic [ADDRSIZE:0] CNT_AEMPTY = (ADDRSIZE + 1)'(AEMPTY_LEVEL);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= AFULL_LEVEL || AFULL_LEVEL > DEPTH) begin : g_bad_levels
      $error("sync_fifo: thresholds must satisfy 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH");
   end

   if (FALLTHROUGH != "TRUE" && FALLTHROUGH != "FALSE") begin : g_bad_fallthrough
      $error("sync_fifo: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
   end

   if (TYPE != "distributed" && TYPE != "block") begin : g_bad_type
      $error("sync_fifo: TYPE must be \"distributed\" or \"block\"");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   // Pointers carry one extra wrap bit so their difference is the occupancy.
   logic [ADDRSIZE:0]   wptr_q, rptr_q;
   logic [ADDRSIZE:0]   wptr_next, rptr_next;
   logic [ADDRSIZE:0]   count_q, count_next;
   logic                full_q, empty_q, afull_q, aempty_q;
   logic                overflow_q, underflow_q;

   logic                wr_accept, rd_accept;
   logic [ADDRSIZE-1:0] waddr, raddr;
   logic [DATASIZE-1:0] mem_rdata;

   // Acceptance uses the registered flags, so a same-cycle read never frees
   // room for a write when full, and a same-cycle write never satisfies a read
   // when empty. Flush overrides both requests.
   assign wr_accept = fifo.wr_en && !full_q  && !fifo.flush;
   assign rd_accept = fifo.rd_en && !empty_q && !fifo.flush;

   assign waddr = wptr_q[ADDRSIZE-1:0];
   assign raddr = rptr_q[ADDRSIZE-1:0];

   // Next pointer values and the occupancy they imply.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      wptr_next = wptr_q;
      rptr_next = rptr_q;
      if (fifo.flush) begin
         wptr_next = '0;
         rptr_next = '0;
      end else begin
         wptr_next = wptr_q + {{ADDRSIZE{1'b0}}, wr_accept};
         rptr_next = rptr_q + {{ADDRSIZE{1'b0}}, rd_accept};
      end
      count_next = wptr_next - rptr_next;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_next;
         rptr_q <= rptr_next;
      end
   end

   // Count and status flags, all registered from the next-state count so they
   // are correct in the cycle right after the edge that changed occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         count_q  <= count_next;
         full_q   <= (count_next == CNT_DEPTH);
         empty_q  <= (count_next == '0);
         afull_q  <= (count_next >= CNT_AFULL);
         aempty_q <= (count_next <= CNT_AEMPTY);
      end
   end

   // Fault pulses: a request that was refused because of full/empty. Flush
   // suppresses both, since neither request is meaningful that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= fifo.wr_en && full_q  && !fifo.flush;
         underflow_q <= fifo.rd_en && empty_q && !fifo.flush;
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   if (TYPE == "block") begin : g_mem_block
      (* ram_style = "block" *) logic [DATASIZE-1:0] mem [DEPTH];

      // Write port.
      always_ff @(posedge clk) begin
         // NOTE: the array has no reset; clearing it would block RAM inference
         // and occupancy already marks every stale entry as invalid.
         if (wr_accept) begin
            mem[waddr] <= fifo.wdata;
         end
      end

      assign mem_rdata = mem[raddr];
   end else begin : g_mem_distributed
      (* ram_style = "distributed" *) logic [DATASIZE-1:0] mem [DEPTH];

      // Write port.
      always_ff @(posedge clk) begin
         if (wr_accept) begin
            mem[waddr] <= fifo.wdata;
         end
      end

      assign mem_rdata = mem[raddr];
   end

   // ------------------------------------------------------------------
   // Read port
   // ------------------------------------------------------------------
   if (FALLTHROUGH == "TRUE") begin : g_read_fwft
      // Head of queue is always presented; valid whenever anything is stored.
      assign fifo.rdata  = mem_rdata;
      assign fifo.rvalid = !empty_q;
   end else begin : g_read_registered
      logic [DATASIZE-1:0] rdata_q;
      logic                rvalid_q;

      // Load the head word on an accepted read; hold it otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) begin
               rdata_q <= mem_rdata;
            end
         end
      end

      assign fifo.rdata  = rdata_q;
      assign fifo.rvalid = rvalid_q;
   end

   // ------------------------------------------------------------------
   // Status outputs
   // ------------------------------------------------------------------
   assign fifo.count        = count_q;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = afull_q;
   assign fifo.almost_empty = aempty_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo. Two instances receive identical stimulus: one
// with a fall-through read port, one with a registered read port. Status bits
// are compared as a packed word {full, empty, afull, aempty, ovf, unf, count}.
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if_f ();
   sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if_r ();

   sync_fifo #(
      .DATASIZE(DW), .ADDRSIZE(AW), .FALLTHROUGH("TRUE"), .TYPE("distributed"),
      .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)
   ) u_fwft (
      .clk  (clk),
      .rst_n(rst_n),
      .fifo (if_f.slave)
   );

   sync_fifo #(
      .DATASIZE(DW), .ADDRSIZE(AW), .FALLTHROUGH("FALSE"), .TYPE("block"),
      .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)
   ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .fifo (if_r.slave)
   );

   logic [10:0] st_f, st_r;
   assign st_f = {if_f.full, if_f.empty, if_f.almost_full, if_f.almost_empty,
                  if_f.overflow, if_f.underflow, if_f.count};
   assign st_r = {if_r.full, if_r.empty, if_r.almost_full, if_r.almost_empty,
                  if_r.overflow, if_r.underflow, if_r.count};

   // Expected status for depth 16, almost_full at >=14, almost_empty at <=2.
   function automatic logic [10:0] exp_st(input int cnt, input bit ovf, input bit unf);
      return {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, ovf, unf, 5'(cnt)};
   endfunction

   task automatic drive(input logic wr, input logic [7:0] wd, input logic rd, input logic fl);
      if_f.wr_en = wr; if_f.wdata = wd; if_f.rd_en = rd; if_f.flush = fl;
      if_r.wr_en = wr; if_r.wdata = wd; if_r.rd_en = rd; if_r.flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL reset_status: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 0));
      end
      vectors++;
      if ({if_f.rvalid, if_r.rvalid, if_r.rdata} !== {1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_read: rvalid_f=%b rvalid_r=%b rdata_r=%h expected 0 0 00",
                  if_f.rvalid, if_r.rvalid, if_r.rdata);
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL post_reset_idle: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 0));
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         tick();
         vectors++;
         if ({st_f, st_r} !== {exp_st(i + 1, 0, 0), exp_st(i + 1, 0, 0)}) begin
            miscompares++;
            $display("FAIL fill_status[%0d]: fwft=%h reg=%h expected=%h", i, st_f, st_r, exp_st(i + 1, 0, 0));
         end
         vectors++;
         if (if_f.rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL fill_head[%0d]: rdata_f=%h expected=00", i, if_f.rdata);
         end
      end
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(16, 1, 0), exp_st(16, 1, 0)}) begin
         miscompares++;
         $display("FAIL overflow_pulse: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(16, 1, 0));
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(16, 0, 0), exp_st(16, 0, 0)}) begin
         miscompares++;
         $display("FAIL overflow_clear: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(16, 0, 0));
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if ({if_f.rvalid, if_f.rdata} !== {1'b1, 8'(i)}) begin
            miscompares++;
            $display("FAIL drain_fwft[%0d]: rvalid=%b rdata=%h expected 1 %h", i, if_f.rvalid, if_f.rdata, 8'(i));
         end
         tick();
         vectors++;
         if ({st_f, st_r} !== {exp_st(15 - i, 0, 0), exp_st(15 - i, 0, 0)}) begin
            miscompares++;
            $display("FAIL drain_status[%0d]: fwft=%h reg=%h expected=%h", i, st_f, st_r, exp_st(15 - i, 0, 0));
         end
         vectors++;
         if ({if_r.rvalid, if_r.rdata} !== {1'b1, 8'(i)}) begin
            miscompares++;
            $display("FAIL drain_reg[%0d]: rvalid=%b rdata=%h expected 1 %h", i, if_r.rvalid, if_r.rdata, 8'(i));
         end
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 1), exp_st(0, 0, 1)}) begin
         miscompares++;
         $display("FAIL underflow_pulse: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 1));
      end
      vectors++;
      if ({if_r.rvalid, if_r.rdata} !== {1'b0, 8'h0F}) begin
         miscompares++;
         $display("FAIL underflow_hold: rvalid=%b rdata=%h expected 0 0f", if_r.rvalid, if_r.rdata);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL underflow_clear: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 0));
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         tick();
      end
      vectors++;
      if ({st_f, st_r} !== {exp_st(5, 0, 0), exp_st(5, 0, 0)}) begin
         miscompares++;
         $display("FAIL simul_preload: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(5, 0, 0));
      end
      // 20 concurrent pushes/pops, then 5 pops; data comes out as 0x10..0x28.
      for (int i = 0; i < 25; i++) begin
         if (i < 20) drive(1'b1, 8'(8'h15 + i), 1'b1, 1'b0);
         else        drive(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if (if_f.rdata !== 8'(8'h10 + i)) begin
            miscompares++;
            $display("FAIL simul_fwft[%0d]: rdata=%h expected=%h", i, if_f.rdata, 8'(8'h10 + i));
         end
         tick();
         vectors++;
         if ({st_f, st_r} !== {exp_st(i < 20 ? 5 : 24 - i, 0, 0), exp_st(i < 20 ? 5 : 24 - i, 0, 0)}) begin
            miscompares++;
            $display("FAIL simul_status[%0d]: fwft=%h reg=%h expected=%h", i, st_f, st_r,
                     exp_st(i < 20 ? 5 : 24 - i, 0, 0));
         end
         vectors++;
         if ({if_r.rvalid, if_r.rdata} !== {1'b1, 8'(8'h10 + i)}) begin
            miscompares++;
            $display("FAIL simul_reg[%0d]: rvalid=%b rdata=%h expected 1 %h", i, if_r.rvalid, if_r.rdata, 8'(8'h10 + i));
         end
      end
      // Empty: write accepted, read refused.
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(1, 0, 1), exp_st(1, 0, 1)}) begin
         miscompares++;
         $display("FAIL simul_empty: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(1, 0, 1));
      end
      vectors++;
      if ({if_f.rdata, if_r.rvalid} !== {8'h77, 1'b0}) begin
         miscompares++;
         $display("FAIL simul_empty_data: rdata_f=%h rvalid_r=%b expected 77 0", if_f.rdata, if_r.rvalid);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({if_r.rvalid, if_r.rdata, st_f} !== {1'b1, 8'h77, exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL simul_empty_pop: rvalid=%b rdata=%h st=%h expected 1 77 %h",
                  if_r.rvalid, if_r.rdata, st_f, exp_st(0, 0, 0));
      end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
         tick();
      end
      vectors++;
      if ({st_f, st_r} !== {exp_st(16, 0, 0), exp_st(16, 0, 0)}) begin
         miscompares++;
         $display("FAIL full_preload: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(16, 0, 0));
      end
      // Full: read accepted, write refused.
      drive(1'b1, 8'hEE, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(15, 1, 0), exp_st(15, 1, 0)}) begin
         miscompares++;
         $display("FAIL full_rw_status: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(15, 1, 0));
      end
      vectors++;
      if ({if_r.rvalid, if_r.rdata, if_f.rdata} !== {1'b1, 8'h80, 8'h81}) begin
         miscompares++;
         $display("FAIL full_rw_data: rvalid_r=%b rdata_r=%h rdata_f=%h expected 1 80 81",
                  if_r.rvalid, if_r.rdata, if_f.rdata);
      end
   endtask

   task automatic test_flush();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (6) tick();
      vectors++;
      if ({st_f, if_r.rdata} !== {exp_st(9, 0, 0), 8'h86}) begin
         miscompares++;
         $display("FAIL flush_preload: st=%h rdata_r=%h expected %h 86", st_f, if_r.rdata, exp_st(9, 0, 0));
      end
      drive(1'b1, 8'h99, 1'b1, 1'b1);
      tick();
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL flush_status: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 0));
      end
      vectors++;
      if ({if_r.rvalid, if_r.rdata, if_f.rvalid} !== {1'b0, 8'h86, 1'b0}) begin
         miscompares++;
         $display("FAIL flush_read: rvalid_r=%b rdata_r=%h rvalid_f=%b expected 0 86 0",
                  if_r.rvalid, if_r.rdata, if_f.rvalid);
      end
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({if_f.rdata, st_f} !== {8'h3C, exp_st(1, 0, 0)}) begin
         miscompares++;
         $display("FAIL flush_refill: rdata_f=%h st=%h expected 3c %h", if_f.rdata, st_f, exp_st(1, 0, 0));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({if_r.rvalid, if_r.rdata, st_r} !== {1'b1, 8'h3C, exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL flush_readback: rvalid=%b rdata=%h st=%h expected 1 3c %h",
                  if_r.rvalid, if_r.rdata, st_r, exp_st(0, 0, 0));
      end
   endtask

   task automatic test_write_through();
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({if_f.rvalid, if_f.rdata, st_f} !== {1'b1, 8'hA5, exp_st(1, 0, 0)}) begin
         miscompares++;
         $display("FAIL write_through: rvalid=%b rdata=%h st=%h expected 1 a5 %h",
                  if_f.rvalid, if_f.rdata, st_f, exp_st(1, 0, 0));
      end
      vectors++;
      if (if_r.rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL write_through_reg: rvalid=%b expected 0", if_r.rvalid);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      vectors++;
      if ({if_r.rvalid, if_r.rdata, st_r} !== {1'b1, 8'hA5, exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL write_through_pop: rvalid=%b rdata=%h st=%h expected 1 a5 %h",
                  if_r.rvalid, if_r.rdata, st_r, exp_st(0, 0, 0));
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if ({st_f, st_r} !== {exp_st(7, 0, 0), exp_st(7, 0, 0)}) begin
         miscompares++;
         $display("FAIL rst_mid_preload: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(7, 0, 0));
      end
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({st_f, st_r} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
         miscompares++;
         $display("FAIL rst_mid_async: fwft=%h reg=%h expected=%h", st_f, st_r, exp_st(0, 0, 0));
      end
      vectors++;
      if ({if_f.rvalid, if_r.rvalid, if_r.rdata} !== {1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL rst_mid_read: rvalid_f=%b rvalid_r=%b rdata_r=%h expected 0 0 00",
                  if_f.rvalid, if_r.rvalid, if_r.rdata);
      end
      rst_n = 1'b1;
      drive(1'b1, 8'h42, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({if_f.rdata, st_f} !== {8'h42, exp_st(1, 0, 0)}) begin
         miscompares++;
         $display("FAIL rst_mid_restart: rdata_f=%h st=%h expected 42 %h", if_f.rdata, st_f, exp_st(1, 0, 0));
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_full_rw();
      test_flush();
      test_write_through();
      test_reset_mid();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
